// File: rtl/video_pattern_gen_if.sv
// Video stream produced by video_pattern_gen: timing strobes, pixel colour and
// the pixel position, all mutually aligned.
interface video_pattern_gen_if #(
  parameter int PIX_SZ = 8,
  parameter int HSZ    = 10,
  parameter int VSZ    = 10
);
  logic              de;
  logic              hsync;
  logic              vsync;
  logic              frame;
  logic [PIX_SZ-1:0] r;
  logic [PIX_SZ-1:0] g;
  logic [PIX_SZ-1:0] b;
  logic [HSZ-1:0]    hcount;
  logic [VSZ-1:0]    vcount;

  modport master (output de, hsync, vsync, frame, r, g, b, hcount, vcount);
  modport slave  (input  de, hsync, vsync, frame, r, g, b, hcount, vcount);
endinterface

// File: rtl/video_pattern_gen.sv
// Pixel-clock video timing plus test pattern source (bars, checker, gradient, solid).
// Optional macro SCROLL_EN: per-frame horizontal scroll of the checker and gradient.
module video_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIX_SZ   = 8,
  parameter int CHK_LOG2 = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              mode_i,
  input  logic [3*PIX_SZ-1:0]     solid_rgb_i,
  video_pattern_gen_if.master     vid_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HSZ     = $clog2(H_TOTAL);
  localparam int VSZ     = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BCW     = $clog2(BAR_W + 1);

  localparam logic [HSZ-1:0] H_LAST   = HSZ'(H_TOTAL - 1);
  localparam logic [VSZ-1:0] V_LAST   = VSZ'(V_TOTAL - 1);
  localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);

  logic [HSZ-1:0]        hcnt_q, hcnt_d;
  logic [VSZ-1:0]        vcnt_q, vcnt_d;
  logic [BCW-1:0]        barCnt_q, barCnt_d;
  logic [2:0]            barIdx_q, barIdx_d;
  logic [1:0]            mode_q, mode_d;
  logic [3*PIX_SZ-1:0]   solid_q, solid_d;

  logic                  de_q, de_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  frame_q, frame_d;
  logic [3*PIX_SZ-1:0]   rgb_q, rgb_d;
  logic [HSZ-1:0]        hcount_q, hcount_d;
  logic [VSZ-1:0]        vcount_q, vcount_d;

  logic                  lineEnd;
  logic                  frameEnd;
  logic                  active;
  logic [HSZ-1:0]        xPos;
  logic [PIX_SZ-1:0]     gray;
  logic                  unused_x;

`ifdef SCROLL_EN
  logic [HSZ-1:0]        offset_q, offset_d;
`endif

  always_comb begin
    lineEnd  = (hcnt_q == H_LAST);
    frameEnd = lineEnd && (vcnt_q == V_LAST);

    hcnt_d = lineEnd ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (lineEnd) begin
      vcnt_d = frameEnd ? '0 : vcnt_q + 1'b1;
    end

    // Bar index steps every BAR_W pixels and sticks at 7, so any remainder
    // pixels past the eighth bar fall into the black bar.
    barCnt_d = barCnt_q;
    barIdx_d = barIdx_q;
    if (lineEnd) begin
      barCnt_d = '0;
      barIdx_d = '0;
    end else if (barCnt_q == BAR_LAST) begin
      barCnt_d = '0;
      barIdx_d = (barIdx_q == 3'd7) ? 3'd7 : barIdx_q + 3'd1;
    end else begin
      barCnt_d = barCnt_q + 1'b1;
    end

    // Pattern controls only change on the frame boundary, so a frame is never torn.
    mode_d  = frameEnd ? mode_i      : mode_q;
    solid_d = frameEnd ? solid_rgb_i : solid_q;
  end

`ifdef SCROLL_EN
  always_comb begin
    offset_d = frameEnd ? offset_q + 1'b1 : offset_q;
    xPos     = hcnt_q + offset_q;
  end
`else
  assign xPos = hcnt_q;
`endif

  generate
    if (HSZ >= PIX_SZ) begin : gGrayTrunc
      assign gray = xPos[PIX_SZ-1:0];
    end else begin : gGrayExt
      assign gray = {{(PIX_SZ - HSZ){1'b0}}, xPos};
    end
  endgenerate

  assign unused_x = ^xPos;

  always_comb begin
    active   = (int'(hcnt_q) < H_ACTIVE) && (int'(vcnt_q) < V_ACTIVE);
    de_d     = active;
    hsync_d  = ((int'(hcnt_q) >= H_ACTIVE + H_FP) &&
                (int'(hcnt_q) <  H_ACTIVE + H_FP + H_SYNC)) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = ((int'(vcnt_q) >= V_ACTIVE + V_FP) &&
                (int'(vcnt_q) <  V_ACTIVE + V_FP + V_SYNC)) ? SYNC_POL : ~SYNC_POL;
    frame_d  = (hcnt_q == '0) && (vcnt_q == '0);
    hcount_d = hcnt_q;
    vcount_d = vcnt_q;

    rgb_d = '0;
    if (active) begin
      case (mode_q)
        2'd0: rgb_d = {{PIX_SZ{~barIdx_q[1]}}, {PIX_SZ{~barIdx_q[2]}}, {PIX_SZ{~barIdx_q[0]}}};
        2'd1: rgb_d = (xPos[CHK_LOG2] ^ vcnt_q[CHK_LOG2]) ? '0 : '1;
        2'd2: rgb_d = {gray, gray, gray};
        2'd3: rgb_d = solid_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      barCnt_q <= '0;
      barIdx_q <= '0;
      mode_q   <= '0;
      solid_q  <= '0;
      de_q     <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      frame_q  <= 1'b0;
      rgb_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
`ifdef SCROLL_EN
      offset_q <= '0;
`endif
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      barCnt_q <= barCnt_d;
      barIdx_q <= barIdx_d;
      mode_q   <= mode_d;
      solid_q  <= solid_d;
      de_q     <= de_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      frame_q  <= frame_d;
      rgb_q    <= rgb_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
`ifdef SCROLL_EN
      offset_q <= offset_d;
`endif
    end
  end

  assign vid_o.de     = de_q;
  assign vid_o.hsync  = hsync_q;
  assign vid_o.vsync  = vsync_q;
  assign vid_o.frame  = frame_q;
  assign vid_o.r      = rgb_q[3*PIX_SZ-1:2*PIX_SZ];
  assign vid_o.g      = rgb_q[2*PIX_SZ-1:PIX_SZ];
  assign vid_o.b      = rgb_q[PIX_SZ-1:0];
  assign vid_o.hcount = hcount_q;
  assign vid_o.vcount = vcount_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Randomized bench for video_pattern_gen against a position-based reference model
// on a shrunken raster so many whole frames fit in a short run.
module tb_video_pattern_gen;

  localparam int HA = 68, HF = 4, HS = 8, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam bit SP = 1'b0;
  localparam int PIX = 8;
  localparam int CHK = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int HSZ = $clog2(HT);
  localparam int VSZ = $clog2(VT);
  localparam int BARW = HA / 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  mode_i = 2'd0;
  logic [23:0] solid_rgb_i = 24'd0;

  int vectors = 0;
  int miscompares = 0;
  int t = 0;
  int mLat = 0;
  logic [23:0] sLat = 24'd0;

  always #5 clk = ~clk;

  video_pattern_gen_if #(.PIX_SZ(PIX), .HSZ(HSZ), .VSZ(VSZ)) vid ();

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(SP), .PIX_SZ(PIX), .CHK_LOG2(CHK)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .mode_i(mode_i),
    .solid_rgb_i(solid_rgb_i),
    .vid_o(vid)
  );

  function automatic logic [23:0] barColour(int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected stream word for raster position pos (cycles since reset release).
  function automatic logic [63:0] modelPixel(int pos, int md, logic [23:0] sol);
    int h, v, f, x, bi;
    logic de, hs, vs, fr;
    logic [23:0] rgb;
    logic [7:0] gr;
    h = pos % HT;
    v = (pos / HT) % VT;
    f = pos / FRAME;
    x = h;
`ifdef SCROLL_EN
    x = (h + f) % (1 << HSZ);
`endif
    de = (h < HA) && (v < VA);
    hs = (h >= HA + HF && h < HA + HF + HS) ? SP : !SP;
    vs = (v >= VA + VF && v < VA + VF + VS) ? SP : !SP;
    fr = (h == 0) && (v == 0);
    rgb = 24'd0;
    if (de) begin
      case (md)
        0: begin
          bi = h / BARW;
          if (bi > 7) bi = 7;
          rgb = barColour(bi);
        end
        1: rgb = (((x >> CHK) ^ (v >> CHK)) & 1) != 0 ? 24'h000000 : 24'hFFFFFF;
        2: begin
          gr = 8'(x % 256);
          rgb = {gr, gr, gr};
        end
        default: rgb = sol;
      endcase
    end
    return 64'({de, hs, vs, fr, HSZ'(h), VSZ'(v), rgb});
  endfunction

  function automatic logic [63:0] obsVec();
    return 64'({vid.de, vid.hsync, vid.vsync, vid.frame, vid.hcount, vid.vcount,
                vid.r, vid.g, vid.b});
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    vectors++;
    if (obs !== expd) begin
      miscompares++;
      $display("[TB] FAIL %s got %h expected %h", tag, obs, expd);
    end
  endtask

  // One clock: compare the registered outputs with the model, then advance the model.
  task automatic applyStimulus();
    logic [63:0] expd;
    @(posedge clk);
    #1;
    if (rst_i) begin
      expd = 64'({1'b0, !SP, !SP, 1'b0, HSZ'(0), VSZ'(0), 24'd0});
      checkOutput("reset", obsVec(), expd);
      t = 0;
      mLat = 0;
      sLat = 24'd0;
    end else begin
      expd = modelPixel(t, mLat, sLat);
      checkOutput($sformatf("pix t=%0d", t), obsVec(), expd);
      if (t % FRAME == FRAME - 1) begin
        mLat = int'(mode_i);
        sLat = solid_rgb_i;
      end
      t++;
    end
  endtask

  task automatic runCycles(input int n);
    int h, v, f;
    for (int i = 0; i < n; i++) begin
      h = t % HT;
      v = (t / HT) % VT;
      f = t / FRAME;
      if (t % FRAME == 0) begin
        mode_i = 2'($urandom_range(0, 3));
        solid_rgb_i = 24'($urandom);
      end else if (v == VT - 2 && h == 0) begin
        mode_i = 2'((f + 1) % 4);
        solid_rgb_i = 24'($urandom);
      end else if (v < VT / 2 && $urandom_range(0, 199) == 0) begin
        mode_i = 2'($urandom_range(0, 3));
        solid_rgb_i = 24'($urandom);
      end
      applyStimulus();
      if (miscompares > 40) break;
    end
  endtask

  initial begin
    rst_i = 1'b1;
    mode_i = 2'($urandom_range(1, 3));
    solid_rgb_i = 24'($urandom);
    repeat (3) applyStimulus();
    rst_i = 1'b0;
    runCycles(7 * FRAME + 7 * HT + 13);

    $display("[TB] mid-frame reset");
    rst_i = 1'b1;
    mode_i = 2'($urandom_range(1, 3));
    repeat (2) applyStimulus();
    rst_i = 1'b0;
    runCycles(4 * FRAME + 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
